bus_cycle_ctrl: RTL and testbench
=================================

// Module: bus_cycle_ctrl
// PURPOSE
//  Fully synchronous, parametrised generation of the Z80 external bus-cycle engine that drives the control pins.
//  Runs fetch, memory read/write, I/O read/write and interrupt-ack cycles. Each T-state is 2 clk cycles, H then L.
//  Handles WAIT insertion, auto-waits, BUSRQ/BUSACK, NMI edge latch, INT sampling and the refresh counter.
//  Sits between the sequencer (cycle requests) and the pin pads.
// PARAMETERS
//  AW             16  address bus width
//  DW              8  data bus width
//  RFSH_W          7  refresh counter width (must be < AW)
//  IO_AUTO_WAIT    1  forced TW states after T2 on I/O cycles (0..3)
//  INTA_AUTO_WAIT  2  forced TW states after T2 on int-ack cycles (0..3)
// PORTS
//  clk         in   1          single clock; every output is registered on its rising edge
//  reset       in   1          synchronous, active-high
//  mwait       in   1          WAIT, positive logic
//  busrq       in   1          bus request, positive logic
//  intr        in   1          maskable interrupt level
//  nmi         in   1          non-maskable interrupt; edge-detected internally
//  cyc_start   in   1          request a cycle; accepted when cyc_start & cyc_ready
//  cyc_type    in   3          0 fetch, 1 mread, 2 mwrite, 3 ioread, 4 iowrite, 5 inta; 6-7 never accepted
//  cyc_addr    in   AW         cycle address, captured on accept
//  cyc_wdata   in   DW         write data, captured on accept
//  rfsh_page   in   AW-RFSH_W  upper refresh address bits (I register)
//  nmi_clr     in   1          clears nmi_pending
//  cyc_ready   out  1          state==IDLE & ~busrq & ~reset
//  cyc_done    out  1          1-clk pulse on the last clk of the cycle
//  cyc_rdata   out  DW         read/fetch/inta data; valid at cyc_done, held until next capture
//  m1,mreq,iorq,rd,wr,rfsh out 1 each  pin strobes, positive logic
//  busack      out  1          bus acknowledge
//  pin_oe      out  1          output enable for address and control pins; = ~(reset|busack), registered
//  ab_out      out  AW         address pad value
//  db_out      out  DW         data pad value
//  db_oe       out  1          data pad output enable
//  db_in       in   DW         data pad input
//  nmi_pending out  1          latched NMI
//  int_pending out  1          sampled intr
// BEHAVIOUR
//  Reset: state IDLE. All strobes, busack, cyc_done, db_oe, pin_oe, nmi_pending, int_pending, rfsh counter,
//   ab_out, db_out and cyc_rdata are 0. pin_oe becomes 1 the clk after reset drops.
//   Reset in mid-cycle aborts the cycle: no cyc_done, all strobes 0 on the next clk.
//  States: IDLE, T1, T2, TWA (auto-wait), TW (WAIT), T3, T4, BUSACK. Each state except IDLE and BUSACK has phases H and L.
//  Accept at edge k -> T1H during clk k+1. ab_out=cyc_addr from T1H. db_out and db_oe from T1L on mwrite/iowrite.
//  Sequences:
//   fetch  T1 T2 [TW*] T3 T4
//   mread/mwrite  T1 T2 [TW*] T3
//   io  T1 T2 TWA*IO_AUTO_WAIT [TW*] T3
//   inta  T1 T2 TWA*INTA_AUTO_WAIT [TW*] T3 T4
//  WAIT: sampled on the last clk of T2 (mem/fetch) or of the last TWA/T2 (io/inta) and of every TW.
//   1 inserts TW (2 clks); 0 proceeds to T3.
//  Strobes:
//   fetch  m1 T1-T2(all TW); mreq T1L..T2..TW, T3H..T4H; rd T1L..T2..TW; rfsh T3,T4.
//   mread  mreq,rd T1L..T3H.
//   mwrite  mreq T1L..T3H; wr T2L..T3H.
//   io  iorq and rd|wr T2H..T3H.
//   inta  m1 T1..TWA/TW; iorq last TWA-L..TW; mreq T3H..T4H; rfsh T3,T4.
//  Fetch/inta: at T3H, ab_out={rfsh_page,rfsh_cnt}.
//  Capture: fetch/inta capture db_in on the last clk before T3; mread/ioread on T3H.
//  cyc_done: last clk (T3L or T4L). rfsh_cnt += 1 mod 2^RFSH_W on done of fetch/inta.
//  Back-to-back: cyc_ready is high on the done clk. If accepted, T1H follows with no IDLE gap.
//  BUSRQ: sampled in IDLE and on the done clk. 1 -> BUSACK next clk: busack=1, pin_oe=0, db_oe=0.
//   Stay while busrq=1. busrq=0 -> IDLE next clk with busack=0. busrq beats cyc_start on the same clk.
//  NMI: rising edge of nmi (vs its registered copy) sets nmi_pending. Set beats nmi_clr on the same clk.
//  int_pending <= intr on each done clk.
// TESTING
//  fetch a=0x1234 -> 8 clks. m1 on clks 1-4, rd on 2-4, rfsh on 5-8, ab=0x1234 then {page,0}, done on clk 8, rfsh_cnt 1.
//  mread with mwait=1 at the first two samples -> 2 TW, done on clk 10, rdata=db_in at T3H.
//  iowrite IO_AUTO_WAIT=1 d=0x5A -> iorq,wr clks 3-7, db_oe clks 2-8, done on clk 8.
//  busrq=1 during fetch -> busack on the clk after done, pin_oe=0, cyc_ready=0. Drop busrq -> busack=0 next clk.
//  nmi edge together with nmi_clr -> pending=1. reset at T2L -> strobes 0 next clk, no done. rfsh_cnt 127 -> 0.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// Z80-style external bus-cycle engine: sequences T-states (two clks each, H then L),
// drives the pin strobes, handles WAIT, auto-waits, bus request, NMI/INT latching and refresh.
module bus_cycle_ctrl #(
  parameter int AW             = 16,
  parameter int DW             = 8,
  parameter int RFSH_W         = 7,
  parameter int IO_AUTO_WAIT   = 1,
  parameter int INTA_AUTO_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mwait,
  input  logic                 busrq,
  input  logic                 intr,
  input  logic                 nmi,
  input  logic                 cyc_start,
  input  logic [2:0]           cyc_type,
  input  logic [AW-1:0]        cyc_addr,
  input  logic [DW-1:0]        cyc_wdata,
  input  logic [AW-RFSH_W-1:0] rfsh_page,
  input  logic                 nmi_clr,
  output logic                 cyc_ready,
  output logic                 cyc_done,
  output logic [DW-1:0]        cyc_rdata,
  output logic                 m1,
  output logic                 mreq,
  output logic                 iorq,
  output logic                 rd,
  output logic                 wr,
  output logic                 rfsh,
  output logic                 busack,
  output logic                 pin_oe,
  output logic [AW-1:0]        ab_out,
  output logic [DW-1:0]        db_out,
  output logic                 db_oe,
  input  logic [DW-1:0]        db_in,
  output logic                 nmi_pending,
  output logic                 int_pending
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4, S_BUSACK
  } state_t;

  localparam logic [2:0] TY_FETCH = 3'd0;
  localparam logic [2:0] TY_MRD   = 3'd1;
  localparam logic [2:0] TY_MWR   = 3'd2;
  localparam logic [2:0] TY_IORD  = 3'd3;
  localparam logic [2:0] TY_IOWR  = 3'd4;
  localparam logic [2:0] TY_INTA  = 3'd5;

  localparam logic [1:0] IO_LAST   = 2'(IO_AUTO_WAIT - 1);
  localparam logic [1:0] INTA_LAST = 2'(INTA_AUTO_WAIT - 1);

  state_t            state_q, state_d;
  logic              ph_q, ph_d;          // 0 = H phase, 1 = L phase
  logic [1:0]        twa_q, twa_d;
  logic [2:0]        typ_q, typ_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [RFSH_W-1:0] rfsh_cnt_q, rfsh_cnt_d;
  logic              nmi_q;
  logic              nmi_pending_q, nmi_pending_d;
  logic              int_pending_q, int_pending_d;
  logic              done_q, done_d;
  logic              m1_q, m1_d, mreq_q, mreq_d, iorq_q, iorq_d;
  logic              rd_q, rd_d, wr_q, wr_d, rfsh_q, rfsh_d;
  logic              busack_q, busack_d;
  logic              pin_oe_q;
  logic              db_oe_q, db_oe_d;
  logic [AW-1:0]     ab_q, ab_d;
  logic [DW-1:0]     db_out_q, db_out_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic acc;
  logic io_q, ifetch_q, ifetch_d, need_twa_q, twa_last_q, twa_last_d;
  logic t1, t2, twa, tw, t3, t4, l;

  assign cyc_ready = (state_q == S_IDLE || done_q) && !busrq && !reset;
  assign acc       = cyc_start && cyc_ready && (cyc_type <= TY_INTA);

  assign io_q       = (typ_q == TY_IORD) || (typ_q == TY_IOWR);
  assign ifetch_q   = (typ_q == TY_FETCH) || (typ_q == TY_INTA);
  assign need_twa_q = (io_q && IO_AUTO_WAIT != 0) || (typ_q == TY_INTA && INTA_AUTO_WAIT != 0);
  assign twa_last_q = (twa_q == (io_q ? IO_LAST : INTA_LAST));

  // Next-state sequencing; the last clk of a cycle behaves like IDLE for busrq/accept.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    twa_d   = twa_q;
    typ_d   = typ_q;
    wdata_d = wdata_q;
    if (acc) begin
      typ_d   = cyc_type;
      wdata_d = cyc_wdata;
    end
    case (state_q)
      S_IDLE: begin
        ph_d = 1'b0;
        if (busrq)    state_d = S_BUSACK;
        else if (acc) state_d = S_T1;
      end
      S_T1: begin
        if (!ph_q) ph_d = 1'b1;
        else begin state_d = S_T2; ph_d = 1'b0; end
      end
      S_T2: begin
        if (!ph_q) ph_d = 1'b1;
        else if (need_twa_q) begin state_d = S_TWA; ph_d = 1'b0; twa_d = 2'd0; end
        else begin state_d = mwait ? S_TW : S_T3; ph_d = 1'b0; end
      end
      S_TWA: begin
        if (!ph_q) ph_d = 1'b1;
        else if (!twa_last_q) begin ph_d = 1'b0; twa_d = twa_q + 2'd1; end
        else begin state_d = mwait ? S_TW : S_T3; ph_d = 1'b0; end
      end
      S_TW: begin
        if (!ph_q) ph_d = 1'b1;
        else begin state_d = mwait ? S_TW : S_T3; ph_d = 1'b0; end
      end
      S_T3, S_T4: begin
        if (!ph_q) ph_d = 1'b1;
        else begin
          ph_d = 1'b0;
          if (state_q == S_T3 && ifetch_q) state_d = S_T4;
          else if (busrq)                  state_d = S_BUSACK;
          else if (acc)                    state_d = S_T1;
          else                             state_d = S_IDLE;
        end
      end
      S_BUSACK: begin
        ph_d = 1'b0;
        if (!busrq) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each registered pin matches its T-state.
  always_comb begin
    t1  = (state_d == S_T1);
    t2  = (state_d == S_T2);
    twa = (state_d == S_TWA);
    tw  = (state_d == S_TW);
    t3  = (state_d == S_T3);
    t4  = (state_d == S_T4);
    l   = ph_d;
    ifetch_d   = (typ_d == TY_FETCH) || (typ_d == TY_INTA);
    twa_last_d = (twa_d == (((typ_d == TY_IORD) || (typ_d == TY_IOWR)) ? IO_LAST : INTA_LAST));
    m1_d   = 1'b0;
    mreq_d = 1'b0;
    iorq_d = 1'b0;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    rfsh_d = 1'b0;
    case (typ_d)
      TY_FETCH: begin
        m1_d   = t1 | t2 | tw;
        mreq_d = (t1 & l) | t2 | tw | t3 | (t4 & ~l);
        rd_d   = (t1 & l) | t2 | tw;
        rfsh_d = t3 | t4;
      end
      TY_MRD: begin
        mreq_d = (t1 & l) | t2 | tw | (t3 & ~l);
        rd_d   = mreq_d;
      end
      TY_MWR: begin
        mreq_d = (t1 & l) | t2 | tw | (t3 & ~l);
        wr_d   = (t2 & l) | tw | (t3 & ~l);
      end
      TY_IORD: begin
        iorq_d = t2 | twa | tw | (t3 & ~l);
        rd_d   = iorq_d;
      end
      TY_IOWR: begin
        iorq_d = t2 | twa | tw | (t3 & ~l);
        wr_d   = iorq_d;
      end
      TY_INTA: begin
        m1_d   = t1 | t2 | twa | tw;
        iorq_d = (twa & l & twa_last_d) | tw | ((INTA_AUTO_WAIT == 0) & t2 & l);
        mreq_d = t3 | (t4 & ~l);
        rfsh_d = t3 | t4;
      end
      default: ;
    endcase

    busack_d = (state_d == S_BUSACK);
    done_d   = l & (t4 | (t3 & ~ifetch_d));
    db_oe_d  = ((typ_d == TY_MWR) || (typ_d == TY_IOWR)) &&
               (t2 | twa | tw | t3 | t4 | (t1 & l));

    db_out_d = db_out_q;
    if (t1 && l) db_out_d = wdata_q;

    ab_d = ab_q;
    if (acc) ab_d = cyc_addr;
    else if (t3 && !l && state_q != S_T3 && ifetch_d) ab_d = {rfsh_page, rfsh_cnt_q};

    // Fetch/inta latch the bus on the clk that leads into T3; plain reads latch during T3H.
    rdata_d = rdata_q;
    if (ifetch_q && t3 && !l && state_q != S_T3) rdata_d = db_in;
    else if ((typ_q == TY_MRD || typ_q == TY_IORD) && state_q == S_T3 && !ph_q) rdata_d = db_in;

    rfsh_cnt_d    = (done_q && ifetch_q) ? rfsh_cnt_q + 1'b1 : rfsh_cnt_q;
    int_pending_d = done_q ? intr : int_pending_q;
    nmi_pending_d = nmi_pending_q;
    if (nmi && !nmi_q) nmi_pending_d = 1'b1;
    else if (nmi_clr)  nmi_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ph_q          <= 1'b0;
      twa_q         <= 2'd0;
      typ_q         <= TY_FETCH;
      wdata_q       <= '0;
      rfsh_cnt_q    <= '0;
      nmi_q         <= 1'b0;
      nmi_pending_q <= 1'b0;
      int_pending_q <= 1'b0;
      done_q        <= 1'b0;
      m1_q          <= 1'b0;
      mreq_q        <= 1'b0;
      iorq_q        <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      rfsh_q        <= 1'b0;
      busack_q      <= 1'b0;
      pin_oe_q      <= 1'b0;
      db_oe_q       <= 1'b0;
      ab_q          <= '0;
      db_out_q      <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      twa_q         <= twa_d;
      typ_q         <= typ_d;
      wdata_q       <= wdata_d;
      rfsh_cnt_q    <= rfsh_cnt_d;
      nmi_q         <= nmi;
      nmi_pending_q <= nmi_pending_d;
      int_pending_q <= int_pending_d;
      done_q        <= done_d;
      m1_q          <= m1_d;
      mreq_q        <= mreq_d;
      iorq_q        <= iorq_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      rfsh_q        <= rfsh_d;
      busack_q      <= busack_d;
      pin_oe_q      <= ~busack_d;
      db_oe_q       <= db_oe_d;
      ab_q          <= ab_d;
      db_out_q      <= db_out_d;
      rdata_q       <= rdata_d;
    end
  end

  assign cyc_done    = done_q;
  assign cyc_rdata   = rdata_q;
  assign m1          = m1_q;
  assign mreq        = mreq_q;
  assign iorq        = iorq_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign rfsh        = rfsh_q;
  assign busack      = busack_q;
  assign pin_oe      = pin_oe_q;
  assign ab_out      = ab_q;
  assign db_out      = db_out_q;
  assign db_oe       = db_oe_q;
  assign nmi_pending = nmi_pending_q;
  assign int_pending = int_pending_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: per-clk strobe tables for each cycle type,
// plus bus request, NMI latching, mid-cycle reset and refresh counter wrap.
module tb_bus_cycle_ctrl;
  logic        clk = 1'b0;
  logic        reset, mwait, busrq, intr, nmi, cyc_start, nmi_clr;
  logic [2:0]  cyc_type;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata, db_in;
  logic [8:0]  rfsh_page;
  logic        cyc_ready, cyc_done, m1, mreq, iorq, rd, wr, rfsh, busack, pin_oe, db_oe;
  logic        nmi_pending, int_pending;
  logic [7:0]  cyc_rdata, db_out;
  logic [15:0] ab_out;
  logic [6:0]  stb;
  int          errors = 0;
  int          checks = 0;

  bus_cycle_ctrl #(.AW(16), .DW(8), .RFSH_W(7), .IO_AUTO_WAIT(1), .INTA_AUTO_WAIT(2)) dut (
    .clk(clk), .reset(reset), .mwait(mwait), .busrq(busrq), .intr(intr), .nmi(nmi),
    .cyc_start(cyc_start), .cyc_type(cyc_type), .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
    .rfsh_page(rfsh_page), .nmi_clr(nmi_clr), .cyc_ready(cyc_ready), .cyc_done(cyc_done),
    .cyc_rdata(cyc_rdata), .m1(m1), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .rfsh(rfsh),
    .busack(busack), .pin_oe(pin_oe), .ab_out(ab_out), .db_out(db_out), .db_oe(db_oe),
    .db_in(db_in), .nmi_pending(nmi_pending), .int_pending(int_pending)
  );

  always #5 clk = ~clk;
  assign stb = {m1, mreq, iorq, rd, wr, rfsh, cyc_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] ty, input logic [15:0] a, input logic [7:0] d);
    cyc_start = 1'b1; cyc_type = ty; cyc_addr = a; cyc_wdata = d;
    tick();
    cyc_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({stb, busack, pin_oe, db_oe, nmi_pending, int_pending, cyc_ready} !== 13'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0", {stb, busack, pin_oe, db_oe, nmi_pending, int_pending, cyc_ready});
    end
    checks++;
    if ({ab_out, db_out, cyc_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_data got=%h want=0", {ab_out, db_out, cyc_rdata});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({pin_oe, cyc_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_release got=%b want=11", {pin_oe, cyc_ready});
    end
  endtask

  task automatic test_fetch();
    logic [6:0]  exp [8];
    logic [15:0] ab_exp;
    exp = '{7'b1000000, 7'b1101000, 7'b1101000, 7'b1101000,
            7'b0100010, 7'b0100010, 7'b0100010, 7'b0000011};
    start(3'd0, 16'h1234, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      db_in = (c == 4) ? 8'hC3 : 8'h00;
      intr  = (c == 8);
      ab_exp = (c < 5) ? 16'h1234 : 16'h2A80;
      checks++;
      if (stb !== exp[c-1]) begin
        errors++; $display("FAIL fetch_strobes clk%0d got=%b want=%b", c, stb, exp[c-1]);
      end
      checks++;
      if (ab_out !== ab_exp) begin
        errors++; $display("FAIL fetch_ab clk%0d got=%h want=%h", c, ab_out, ab_exp);
      end
      tick();
    end
    intr = 1'b0;
    checks++;
    if (cyc_rdata !== 8'hC3) begin
      errors++; $display("FAIL fetch_rdata got=%h want=c3", cyc_rdata);
    end
    checks++;
    if (int_pending !== 1'b1) begin
      errors++; $display("FAIL fetch_int_pending got=%b want=1", int_pending);
    end
  endtask

  task automatic test_mread_wait();
    logic [6:0] want;
    start(3'd1, 16'h0F0F, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      mwait = (c == 4) || (c == 6);
      db_in = (c == 9) ? 8'hA7 : 8'h11;
      want  = (c == 1) ? 7'b0000000 : (c == 10) ? 7'b0000001 : 7'b0101000;
      checks++;
      if (stb !== want) begin
        errors++; $display("FAIL mread_strobes clk%0d got=%b want=%b", c, stb, want);
      end
      if (c == 10) begin
        checks++;
        if (cyc_rdata !== 8'hA7) begin
          errors++; $display("FAIL mread_rdata got=%h want=a7", cyc_rdata);
        end
      end
      tick();
    end
    mwait = 1'b0;
    checks++;
    if (int_pending !== 1'b0) begin
      errors++; $display("FAIL mread_int_pending got=%b want=0", int_pending);
    end
  endtask

  task automatic test_iowrite();
    logic [6:0] want;
    start(3'd4, 16'h00FE, 8'h5A);
    for (int c = 1; c <= 8; c++) begin
      want = (c <= 2) ? 7'b0000000 : (c == 8) ? 7'b0000001 : 7'b0010100;
      checks++;
      if (stb !== want) begin
        errors++; $display("FAIL iowr_strobes clk%0d got=%b want=%b", c, stb, want);
      end
      checks++;
      if (db_oe !== (c >= 2)) begin
        errors++; $display("FAIL iowr_db_oe clk%0d got=%b want=%b", c, db_oe, (c >= 2));
      end
      if (c == 2) begin
        checks++;
        if (db_out !== 8'h5A) begin
          errors++; $display("FAIL iowr_db_out got=%h want=5a", db_out);
        end
      end
      tick();
    end
    checks++;
    if (db_oe !== 1'b0) begin
      errors++; $display("FAIL iowr_db_oe_after got=%b want=0", db_oe);
    end
  endtask

  task automatic test_inta();
    logic [6:0] want;
    start(3'd5, 16'h0038, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      db_in = (c == 8) ? 8'h3C : 8'hFF;
      want = (c <= 7) ? 7'b1000000 : (c == 8) ? 7'b1010000 :
             (c == 12) ? 7'b0000011 : 7'b0100010;
      checks++;
      if (stb !== want) begin
        errors++; $display("FAIL inta_strobes clk%0d got=%b want=%b", c, stb, want);
      end
      if (c == 9) begin
        checks++;
        if (ab_out !== 16'h2A81) begin
          errors++; $display("FAIL inta_rfsh_ab got=%h want=2a81", ab_out);
        end
      end
      if (c == 12) begin
        checks++;
        if (cyc_rdata !== 8'h3C) begin
          errors++; $display("FAIL inta_rdata got=%h want=3c", cyc_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    start(3'd1, 16'h0BAD, 8'h00);
    for (int c = 1; c < 6; c++) tick();
    checks++;
    if ({cyc_done, cyc_ready} !== 2'b11) begin
      errors++; $display("FAIL b2b_done_ready got=%b want=11", {cyc_done, cyc_ready});
    end
    start(3'd0, 16'h4000, 8'h00);
    checks++;
    if (stb !== 7'b1000000 || ab_out !== 16'h4000) begin
      errors++; $display("FAIL b2b_t1 got=%b/%h want=1000000/4000", stb, ab_out);
    end
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (c == 5) begin
        checks++;
        if (ab_out !== 16'h2A82) begin
          errors++; $display("FAIL b2b_rfsh_ab got=%h want=2a82", ab_out);
        end
      end
    end
    checks++;
    if (stb !== 7'b0000011) begin
      errors++; $display("FAIL b2b_done got=%b want=0000011", stb);
    end
    tick();
  endtask

  task automatic test_busrq();
    start(3'd0, 16'h0100, 8'h00);
    for (int c = 1; c < 8; c++) begin
      if (c == 3) busrq = 1'b1;
      tick();
    end
    checks++;
    if ({cyc_done, cyc_ready} !== 2'b10) begin
      errors++; $display("FAIL busrq_done_ready got=%b want=10", {cyc_done, cyc_ready});
    end
    cyc_start = 1'b1; cyc_type = 3'd0;
    tick();
    cyc_start = 1'b0;
    checks++;
    if ({busack, pin_oe, cyc_ready, db_oe, stb} !== {4'b1000, 7'b0}) begin
      errors++; $display("FAIL busrq_ack got=%b want=10000000000", {busack, pin_oe, cyc_ready, db_oe, stb});
    end
    tick();
    checks++;
    if (busack !== 1'b1) begin
      errors++; $display("FAIL busrq_hold got=%b want=1", busack);
    end
    busrq = 1'b0;
    tick();
    checks++;
    if ({busack, pin_oe, cyc_ready} !== 3'b011) begin
      errors++; $display("FAIL busrq_release got=%b want=011", {busack, pin_oe, cyc_ready});
    end
  endtask

  task automatic test_nmi();
    nmi = 1'b1; nmi_clr = 1'b1;
    tick();
    checks++;
    if (nmi_pending !== 1'b1) begin
      errors++; $display("FAIL nmi_set_beats_clr got=%b want=1", nmi_pending);
    end
    tick();
    checks++;
    if (nmi_pending !== 1'b0) begin
      errors++; $display("FAIL nmi_clr_level got=%b want=0", nmi_pending);
    end
    nmi_clr = 1'b0; nmi = 1'b0;
    tick();
    nmi = 1'b1;
    tick();
    checks++;
    if (nmi_pending !== 1'b1) begin
      errors++; $display("FAIL nmi_edge got=%b want=1", nmi_pending);
    end
    nmi = 1'b0; nmi_clr = 1'b1;
    tick();
    nmi_clr = 1'b0;
    checks++;
    if (nmi_pending !== 1'b0) begin
      errors++; $display("FAIL nmi_clear got=%b want=0", nmi_pending);
    end
  endtask

  task automatic test_reset_mid();
    start(3'd1, 16'h2222, 8'h00);
    for (int c = 1; c < 4; c++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({stb, pin_oe, cyc_ready} !== 9'b0) begin
      errors++; $display("FAIL rstmid_abort got=%b want=0", {stb, pin_oe, cyc_ready});
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({stb, pin_oe, cyc_ready} !== 9'b000000011) begin
      errors++; $display("FAIL rstmid_release got=%b want=000000011", {stb, pin_oe, cyc_ready});
    end
  endtask

  task automatic test_rfsh_wrap();
    logic [15:0] abv;
    abv = 16'h0;
    for (int n = 0; n < 129; n++) begin
      start(3'd0, 16'h8000, 8'h00);
      for (int c = 1; c <= 8; c++) begin
        if (c == 5) abv = ab_out;
        tick();
      end
      if (n == 127) begin
        checks++;
        if (abv !== 16'h2AFF) begin
          errors++; $display("FAIL rfsh_127 got=%h want=2aff", abv);
        end
      end
      if (n == 128) begin
        checks++;
        if (abv !== 16'h2A80) begin
          errors++; $display("FAIL rfsh_wrap got=%h want=2a80", abv);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; mwait = 1'b0; busrq = 1'b0; intr = 1'b0; nmi = 1'b0; nmi_clr = 1'b0;
    cyc_start = 1'b0; cyc_type = 3'd0; cyc_addr = 16'h0; cyc_wdata = 8'h0;
    db_in = 8'h0; rfsh_page = 9'h055;
    test_reset();
    test_fetch();
    test_mread_wait();
    test_iowrite();
    test_inta();
    test_back_to_back();
    test_busrq();
    test_nmi();
    test_reset_mid();
    test_rfsh_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
